// File: rtl/alu_op_driver_pkg.sv
// Shared encodings for the add/sub operation driver: FSM states and op select values.
package alu_op_driver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/alu_op_settle_cnt.sv
// 4-bit settle counter: load on command accept, count down while operands settle, flag zero.
module alu_op_settle_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/alu_op_driver.sv
// Initiator for the combinational add/sub unit: registers a command, waits SETTLE_CYCLES, captures c.
// Optional result checker (chk_err port) is built when ALU_OP_DRIVER_CHECK_EN is defined.
module alu_op_driver
  import alu_op_driver_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  input  logic [WIDTH:0]   alu_c,
`ifdef ALU_OP_DRIVER_CHECK_EN
  output logic             chk_err,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic             res_zero,
  output logic             res_msb,
  output logic             busy
);

  // Both handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds valid and payload stable until then, ready may change freely.

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t state, state_next;
  logic   accept;
  logic   cnt_zero;

  assign cmd_ready = (state == IDLE) || ((state == HOLD) && res_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  alu_op_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .dec      (state == DRIVE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   if (cnt_zero) state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (res_ready) state_next = accept ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_msb   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_op;
      end
      if (state == CAPTURE) begin
        res_data  <= alu_c;
        res_zero  <= (alu_c[WIDTH-1:0] == '0);
        res_msb   <= alu_c[WIDTH];
        res_valid <= 1'b1;
      end else if ((state == HOLD) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_OP_DRIVER_CHECK_EN
  // Sticky: one wrong result from the unit stays visible until reset.
  logic [WIDTH:0] chk_exp;

  assign chk_exp = (alu_sel == OP_ADD) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                       : ({1'b0, alu_a} - {1'b0, alu_b});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if ((state == CAPTURE) && (alu_c != chk_exp)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver with a behavioural add/sub unit on the alu_* side.
module tb_alu_op_driver;

  localparam int WIDTH = 4;
`ifdef ALU_OP_DRIVER_CHECK_EN
  localparam int             SETTLE = 3;
  localparam logic [WIDTH:0] FLIP   = 5'd1;
`else
  localparam int             SETTLE = 1;
  localparam logic [WIDTH:0] FLIP   = 5'd0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_sel;
  logic [WIDTH:0]   alu_c;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH:0]   res_data;
  logic             res_zero;
  logic             res_msb;
  logic             busy;
`ifdef ALU_OP_DRIVER_CHECK_EN
  logic             chk_err;
`endif

  alu_op_driver #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_c     (alu_c),
`ifdef ALU_OP_DRIVER_CHECK_EN
    .chk_err   (chk_err),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_msb   (res_msb),
    .busy      (busy)
  );

  // Stand-in arithmetic unit; FLIP corrupts bit 0 so the checker build sees a faulty unit.
  assign alu_c = (alu_sel ? ({1'b0, alu_a} + {1'b0, alu_b})
                          : ({1'b0, alu_a} - {1'b0, alu_b})) ^ FLIP;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH:0] hand_exp);
    logic [WIDTH:0] e;
    e = hand_exp ^ FLIP;
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"},  32'(res_data), 32'(e));
    check({tag, "_zero"},  32'(res_zero), 32'(e[WIDTH-1:0] == '0));
    check({tag, "_msb"},   32'(res_msb),  32'(e[WIDTH]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op);
    int waited;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 40) begin
      step();
      waited++;
    end
    if (waited >= 40) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [WIDTH:0]   exp;
  } vec_t;

  vec_t b2b_tbl[4];

  initial begin
    int lat;
    int got;
    int idx;
    int last_cyc;
    logic saw_valid;

    b2b_tbl[0] = '{a: 4'd1,  b: 4'd2, op: 1'b1, exp: 5'd3};
    b2b_tbl[1] = '{a: 4'd15, b: 4'd1, op: 1'b1, exp: 5'd16};
    b2b_tbl[2] = '{a: 4'd0,  b: 4'd1, op: 1'b0, exp: 5'b11111};
    b2b_tbl[3] = '{a: 4'd8,  b: 4'd3, op: 1'b0, exp: 5'd5};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_sel",   32'(alu_sel),   32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
`ifdef ALU_OP_DRIVER_CHECK_EN
    check("rst_chk_err",   32'(chk_err),   32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // add 9 + 8 = 17, carry out
    send(4'd9, 4'd8, 1'b1);
    check("add_busy",      32'(busy),      32'd1);
    check("add_cmd_ready", 32'(cmd_ready), 32'd0);
    check("add_alu_a",     32'(alu_a),     32'd9);
    check("add_alu_b",     32'(alu_b),     32'd8);
    check("add_alu_sel",   32'(alu_sel),   32'd1);
    wait_result(lat);
    check("add_latency", 32'(lat), 32'(SETTLE + 1));
    check_result("add", 5'd17);
`ifdef ALU_OP_DRIVER_CHECK_EN
    check("chk_err_first", 32'(chk_err), 32'd1);
`endif
    consume();
    check("add_done_valid", 32'(res_valid), 32'd0);
    check("add_done_busy",  32'(busy),      32'd0);

    // subtract with wrap, then exact zero
    send(4'd3, 4'd5, 1'b0);
    wait_result(lat);
    check_result("sub_wrap", 5'b11110);
    consume();
    send(4'd7, 4'd7, 1'b0);
    wait_result(lat);
    check_result("sub_zero", 5'd0);
    consume();

    // backpressure: result must hold for 5 cycles
    send(4'd15, 4'd15, 1'b1);
    wait_result(lat);
    check_result("bp", 5'd30);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_data",  32'(res_data),  32'(5'd30 ^ FLIP));
      check("bp_cmd_ready",  32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_bypass_ready", 32'(cmd_ready), 32'd1);
    step();
    res_ready = 1'b0;
    check("bp_release_valid", 32'(res_valid), 32'd0);
    check("bp_release_busy",  32'(busy),      32'd0);

    // back-to-back with res_ready held high
    res_ready = 1'b1;
    idx = 0;
    got = 0;
    last_cyc = 0;
    cmd_a = b2b_tbl[0].a; cmd_b = b2b_tbl[0].b; cmd_op = b2b_tbl[0].op; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected", 32'(res_data), 32'h0);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front() ^ FLIP;
          check("b2b_data", 32'(res_data), 32'(e));
          check("b2b_msb",  32'(res_msb),  32'(e[WIDTH]));
        end
        if (got > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'(SETTLE + 2));
        last_cyc = cyc;
        got++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(b2b_tbl[idx].exp);
        idx++;
      end
      step();
      if (idx < 4) begin
        cmd_a = b2b_tbl[idx].a; cmd_b = b2b_tbl[idx].b; cmd_op = b2b_tbl[idx].op;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_count", 32'(got), 32'd4);
    res_ready = 1'b0;
    step();
`ifdef ALU_OP_DRIVER_CHECK_EN
    check("chk_err_sticky", 32'(chk_err), 32'd1);
`endif

    // reset while the operands are being driven
    send(4'd5, 4'd5, 1'b1);
    check("mid_state_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (SETTLE + 4) begin
      step();
      if (res_valid) saw_valid = 1'b1;
    end
    check("mid_rst_discard", 32'(saw_valid), 32'd0);
`ifdef ALU_OP_DRIVER_CHECK_EN
    check("chk_err_cleared", 32'(chk_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Initiator side of the combinational add/sub unit interface (a, b, sel -> c).
- Accepts operation commands through a valid/ready handshake and drives operands and sel onto the unit.
- Waits a programmable settle time, captures the (WIDTH+1)-bit result, and presents it with status flags on an output valid/ready handshake.
- Sits between the command sequencer and the arithmetic unit, so upstream logic never touches the unregistered path.

Parameters:
- WIDTH, 4, operand width; result width is WIDTH+1.
- SETTLE_CYCLES, 1, cycles operands are held stable before capture (legal range 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command.
- cmd_op  input  1  1 = add, 0 = subtract; same encoding as the unit's sel.
- cmd_a  input  WIDTH  operand a.
- cmd_b  input  WIDTH  operand b.
- alu_a  output  WIDTH  operand a to the unit.
- alu_b  output  WIDTH  operand b to the unit.
- alu_sel  output  1  op select to the unit.
- alu_c  input  WIDTH+1  result from the unit.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH+1  captured result.
- res_zero  output  1  res_data[WIDTH-1:0] == 0.
- res_msb  output  1  res_data[WIDTH]; carry for add, borrow/wrap for subtract.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - alu_a, alu_b, res_data = 0; alu_sel = 0.
  - res_valid, res_zero, res_msb, busy = 0.
  - cmd_ready = 1 once rst_n is released.
- FSM states: IDLE, DRIVE, CAPTURE, HOLD.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: register cmd_a, cmd_b, cmd_op into alu_a, alu_b, alu_sel; load settle counter with SETTLE_CYCLES-1; go to DRIVE.
- DRIVE:
  - alu_a, alu_b and alu_sel are held stable.
  - Counter decrements each cycle; when it reaches 0, go to CAPTURE.
- CAPTURE (one cycle):
  - res_data <= alu_c.
  - res_zero <= (alu_c[WIDTH-1:0] == 0).
  - res_msb <= alu_c[WIDTH].
  - res_valid <= 1; go to HOLD.
- HOLD:
  - res_valid = 1; res_data and flags are stable until the handshake completes.
  - On res_ready, clear res_valid and go to IDLE.
  - cmd_ready = 1 in HOLD only when res_ready = 1 (bypass). A command accepted in that cycle goes directly to DRIVE.
- Latency, command accept to res_valid high:
  - SETTLE_CYCLES+1 cycles.
  - With the default, 2 cycles.
  - Back-to-back throughput: one result every SETTLE_CYCLES+2 cycles.
- cmd_ready is 0 in DRIVE and CAPTURE.
- cmd_valid must hold with stable data until accepted; the driver ignores command inputs while cmd_ready = 0.
- Arithmetic convention, which the bench model mirrors:
  - add = zero-extended a + b.
  - subtract = (a - b) mod 2^(WIDTH+1).
  - Example: 3 - 5 = 5'b11110.
- res_ready held high before res_valid rises: the transfer completes in the first HOLD cycle.
- Reset mid-operation: any state returns to IDLE immediately and the in-flight result is discarded.

Optional Feature:
- Macro: ALU_OP_DRIVER_CHECK_EN.
- Enabled:
  - Adds an output port chk_err (1 bit, reset 0).
  - In CAPTURE, computes the expected result internally from alu_a/alu_b/alu_sel using the arithmetic convention above.
  - On mismatch with alu_c, sets chk_err sticky; only reset clears it.
- Disabled: no port and no checker logic; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, DRIVE=2'd1, CAPTURE=2'd2, HOLD=2'd3);
  - op encoding constants (OP_ADD=1'b1, OP_SUB=1'b0).
- Natural sub-module: alu_op_settle_cnt, a 4-bit load/decrement/zero-detect counter.

Test Plan:
- Reset: assert rst_n=0 mid-DRIVE -> next cycle state IDLE, res_valid=0, alu_a=0, cmd_ready=1 after release.
- Add: cmd a=4'd9, b=4'd8, op=1 -> res_valid 2 cycles after accept, res_data=5'd17, res_msb=1, res_zero=0.
- Subtract wrap: a=3, b=5, op=0 -> res_data=5'b11110, res_msb=1; then a=7, b=7 -> res_data=0, res_zero=1.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0; release -> transfer completes in 1 cycle.
- Back-to-back: res_ready=1, cmd_valid continuously with 4 commands -> 4 results in order, spacing 3 cycles.
- SETTLE_CYCLES=3 build plus ALU_OP_DRIVER_CHECK_EN with the stub unit returning c^1 -> latency 4, chk_err=1 after first capture, stays 1.
